msg_scroll_display: RTL
=======================

Name: msg_scroll_display

Overview:
Parametrised successor to the fixed four-letter difficulty display. It drives NUM_DIGITS seven-segment digits from a small message ROM (EASY / HARD / HELL / dashes). It has three display modes: static, right-to-left scroll and blink. It sits between the game FSM (which supplies the difficulty and a load strobe) and the board HEX pins.

Parameters:
NUM_DIGITS, 4, number of seven-seg digits driven (1..8)
MSG_LEN, 4, padded message length in characters (>=4); characters past index 3 are blank
SCROLL_DIV, 15_000_000, clk cycles per scroll step (>=2)
BLINK_DIV, 25_000_000, clk cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
msg_sel  input  2  message select: 0 EASY, 1 HARD, 2 HELL, 3 "----"
mode  input  2  0 static, 1 scroll, 2 blink, 3 reserved (behaves as static)
load  input  1  single-cycle strobe; samples msg_sel and mode
hex_out  output  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit NUM_DIGITS-1 is in the MS bits and is the leftmost
wrap  output  1  one-cycle pulse when the scroll position wraps to 0

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high. All state and all outputs are registered.
- Reset state:
  - msg_q=0, mode_q=0, pos=0, blink_on=1.
  - Both divider counters are 0.
  - hex_out = all ones (blank). wrap = 0.
- Load:
  - When load=1 at a clock edge: msg_q<=msg_sel, mode_q<=mode, pos<=0, blink_on<=1, both divider counters<=0.
  - load has priority over any tick in the same cycle.
  - msg_sel and mode are ignored when load=0.
- Dividers:
  - Scroll counter counts 0..SCROLL_DIV-1; scroll_tick is asserted when count==SCROLL_DIV-1, then the counter returns to 0.
  - Tick period is exactly SCROLL_DIV cycles. The blink counter works the same way with BLINK_DIV.
  - Both counters free-run in every mode.
- Scroll (mode_q=1):
  - Virtual sequence length L = MSG_LEN + NUM_DIGITS. Indices >= MSG_LEN are blank (trailing gap).
  - On scroll_tick: pos <= (pos==L-1) ? 0 : pos+1.
  - wrap is registered and pulses high for one cycle, the cycle after pos goes L-1 -> 0.
  - Leftmost digit k=0 (hex_out MS digit) shows char index (pos+k) mod L; digit k shows index (pos+k) mod L.
- Static (mode_q=0 or 3):
  - Leftmost digit shows char 0, next char 1, and so on. Digits beyond MSG_LEN show blank.
  - pos is held at 0 and wrap stays 0.
- Blink (mode_q=2):
  - Same content as static.
  - blink_on toggles on each blink_tick. While blink_on=0, all digits are blank.
- Output latency: hex_out reflects state one cycle after that state changes. After a load, the new message is on hex_out exactly 2 cycles after the load edge.
- Glyphs (active-low, gfedcba):
  - E=0000110, A=0001000, S=0010010, Y=0010001
  - H=0001001, r=0101111, d=0100001, L=1000111
  - dash=0111111, blank=1111111
- Reset asserted mid-scroll or mid-blink returns the block to the reset state on that edge. No partial update of hex_out.
- Arithmetic:
  - pos width = clog2(L).
  - Modulo is done by compare-subtract (pos+k < 2L); no divider.

Decomposition:
- Shared package display_pkg holds:
  - 4-bit char code enum: CH_E, CH_A, CH_S, CH_Y, CH_H, CH_R, CH_D, CH_L, CH_DASH, CH_BLANK.
  - The glyph constants.
  - The msg_rom function (msg_sel, index) -> char code.
  - The mode encodings.
- One sub-module, seg7_char_decode: a combinational char code -> 7-bit active-low glyph, instantiated NUM_DIGITS times via generate.

Test Plan:
All scenarios use NUM_DIGITS=4, MSG_LEN=4, SCROLL_DIV=4, BLINK_DIV=3.
- Reset held 3 cycles -> hex_out=all ones, wrap=0. One cycle after release -> EASY static: 0000110_0001000_0010010_0010001.
- load with msg_sel=1, mode=0 -> 2 cycles later hex_out = H,A,r,d. Changing msg_sel without load -> no change.
- load with msg_sel=2, mode=1 -> display steps every 4 cycles: HELL, ELL_, LL__, L___, ____, ___H, __HE, _HEL, HELL. wrap pulses once per 32 cycles, coincident with the return to HELL.
- load with msg_sel=0, mode=2 -> EASY visible 3 cycles, blank 3, visible 3. A load mid-blank restores visible on the next update.
- load and scroll_tick in the same cycle -> pos=0, no step taken. Reset asserted mid-scroll at pos=5 -> blank next cycle, then EASY static.
- msg_sel=3, mode=3 -> "----" static (0111111 x4), wrap stays 0 for 100 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared character codes, glyphs, mode encodings and the message ROM
// for the scrolling seven-segment message display.
package display_pkg;

  typedef enum logic [3:0] {
    CH_E,
    CH_A,
    CH_S,
    CH_Y,
    CH_H,
    CH_R,
    CH_D,
    CH_L,
    CH_DASH,
    CH_BLANK
  } char_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_S     = 7'b0010010;
  localparam logic [6:0] GLYPH_Y     = 7'b0010001;
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SCROLL = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  function automatic char_t msg_rom(input logic [1:0] sel, input logic [1:0] idx);
    char_t ch;
    ch = CH_BLANK;
    case (sel)
      2'd0: case (idx)
        2'd0: ch = CH_E;
        2'd1: ch = CH_A;
        2'd2: ch = CH_S;
        default: ch = CH_Y;
      endcase
      2'd1: case (idx)
        2'd0: ch = CH_H;
        2'd1: ch = CH_A;
        2'd2: ch = CH_R;
        default: ch = CH_D;
      endcase
      2'd2: case (idx)
        2'd0: ch = CH_H;
        2'd1: ch = CH_E;
        default: ch = CH_L;
      endcase
      default: ch = CH_DASH;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character code to active-low seven-segment glyph.
module seg7_char_decode
  import display_pkg::*;
(
  input  char_t      ch,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (ch)
      CH_E:    glyph = GLYPH_E;
      CH_A:    glyph = GLYPH_A;
      CH_S:    glyph = GLYPH_S;
      CH_Y:    glyph = GLYPH_Y;
      CH_H:    glyph = GLYPH_H;
      CH_R:    glyph = GLYPH_R;
      CH_D:    glyph = GLYPH_D;
      CH_L:    glyph = GLYPH_L;
      CH_DASH: glyph = GLYPH_DASH;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/msg_scroll_display.sv
// Multi-digit message display with static, right-to-left scroll and blink
// modes; all outputs registered one cycle behind the display state.
module msg_scroll_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 4,
  parameter int SCROLL_DIV = 15_000_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              msg_sel,
  input  logic [1:0]              mode,
  input  logic                    load,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    wrap
);

  localparam int SEQ_LEN = MSG_LEN + NUM_DIGITS;
  localparam int PW      = $clog2(SEQ_LEN);
  localparam int SW      = $clog2(SCROLL_DIV);
  localparam int BW      = $clog2(BLINK_DIV);

  localparam logic [PW:0]   SEQ_LEN_W  = (PW+1)'(SEQ_LEN);
  localparam logic [PW:0]   MSG_LEN_W  = (PW+1)'(MSG_LEN);
  localparam logic [PW:0]   ROM_LEN_W  = (PW+1)'(4);
  localparam logic [PW-1:0] POS_LAST   = PW'(SEQ_LEN - 1);
  localparam logic [SW-1:0] SCNT_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK_DIV - 1);

  logic [1:0]    msg_reg;
  logic [1:0]    mode_reg;
  logic [PW-1:0] pos_reg;
  logic          blink_on_reg;
  logic [SW-1:0] scnt_reg;
  logic [BW-1:0] bcnt_reg;

  logic                    scroll_tick;
  logic                    blink_tick;
  logic [7*NUM_DIGITS-1:0] glyph_bus;

  assign scroll_tick = (scnt_reg == SCNT_LAST);
  assign blink_tick  = (bcnt_reg == BCNT_LAST);

  // Digit gi sits at bit slice gi; its left-to-right position is k.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam logic [PW:0] K_W = (PW+1)'(NUM_DIGITS - 1 - gi);

    logic [PW:0] sum;
    logic [PW:0] idx;
    char_t       ch;
    logic [6:0]  glyph;

    always_comb begin
      sum = {1'b0, pos_reg} + K_W;
      // pos+k stays below 2L, so one conditional subtract is a full modulo
      idx = (mode_reg == MODE_SCROLL) ? ((sum >= SEQ_LEN_W) ? sum - SEQ_LEN_W : sum) : K_W;
      if (mode_reg == MODE_BLINK && !blink_on_reg) begin
        ch = CH_BLANK;
      end else if (idx < MSG_LEN_W && idx < ROM_LEN_W) begin
        ch = msg_rom(msg_reg, idx[1:0]);
      end else begin
        ch = CH_BLANK;
      end
    end

    seg7_char_decode u_decode (
      .ch    (ch),
      .glyph (glyph)
    );

    assign glyph_bus[gi*7 +: 7] = glyph;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_reg      <= 2'd0;
      mode_reg     <= MODE_STATIC;
      pos_reg      <= '0;
      blink_on_reg <= 1'b1;
      scnt_reg     <= '0;
      bcnt_reg     <= '0;
      hex_out      <= '1;
      wrap         <= 1'b0;
    end else begin
      hex_out  <= glyph_bus;
      wrap     <= 1'b0;
      scnt_reg <= scroll_tick ? '0 : scnt_reg + SW'(1);
      bcnt_reg <= blink_tick ? '0 : bcnt_reg + BW'(1);
      if (load) begin
        msg_reg      <= msg_sel;
        mode_reg     <= mode;
        pos_reg      <= '0;
        blink_on_reg <= 1'b1;
        scnt_reg     <= '0;
        bcnt_reg     <= '0;
      end else begin
        if (scroll_tick && mode_reg == MODE_SCROLL) begin
          if (pos_reg == POS_LAST) begin
            pos_reg <= '0;
            wrap    <= 1'b1;
          end else begin
            pos_reg <= pos_reg + PW'(1);
          end
        end
        if (blink_tick) begin
          blink_on_reg <= ~blink_on_reg;
        end
      end
    end
  end

endmodule
